// File: rtl/triangle_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : triangle_scheduler
// Brief    : Walks one frame of scene triangles, resolves the three vertex
//            indices through the vertex table and issues one triangle per
//            valid/ready handshake towards the transform/raster pipeline.
// Revision : 1.0 - initial release
// ============================================================================
// Packing of the geometry buses (scene_objects side and tri_* outputs):
//   vertex   [29:0] = {x[9:0], y[9:0], z[9:0]}            (each signed)
//   triangle [20:0] = {v0[2:0], v1[2:0], v2[2:0], r, g, b} (colour 4b each)
//   tri_color[11:0] = {r, g, b}
// ============================================================================
module triangle_scheduler #(
    parameter int MAX_TRIS = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic [1:0]                  model_select_in,
    output logic [1:0]                  model_sel,
    input  logic [7:0][29:0]            scene_vertices,
    input  logic [MAX_TRIS-1:0][20:0]   scene_triangles,
    input  logic [3:0]                  num_triangles,
    output logic                        tri_valid,
    input  logic                        tri_ready,
    output logic [29:0]                 tri_v0,
    output logic [29:0]                 tri_v1,
    output logic [29:0]                 tri_v2,
    output logic [11:0]                 tri_color,
    output logic [3:0]                  tri_index,
    output logic                        tri_last,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam int         c_IDX_W    = (MAX_TRIS > 1) ? $clog2(MAX_TRIS) : 1;
    localparam logic [4:0] c_MAX_CNT  = 5'(MAX_TRIS);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_count;
    logic        r_first;       // first FETCH of the frame: count is re-sampled
    logic [1:0]  r_model_sel;
    logic        r_tri_valid;
    logic [29:0] r_tri_v0;
    logic [29:0] r_tri_v1;
    logic [29:0] r_tri_v2;
    logic [11:0] r_tri_color;
    logic [3:0]  r_tri_index;
    logic        r_tri_last;
    logic        r_frame_done;
    logic        r_busy;
    logic        r_overrun;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [3:0]  w_num_clamped;
    logic [3:0]  w_count;
    logic [20:0] w_tri;

    // Clamp the source count, pick the count that is valid in this FETCH and
    // look up the current triangle.
    always_comb begin
        w_num_clamped = ({1'b0, num_triangles} > c_MAX_CNT) ? c_MAX_CNT[3:0]
                                                            : num_triangles;
        // The geometry source reacts combinationally to model_sel, so the
        // count seen in the first FETCH of a frame is the authoritative one.
        w_count       = r_first ? w_num_clamped : r_count;
        w_tri         = scene_triangles[r_idx[c_IDX_W-1:0]];
    end

    // Frame sequencer: IDLE -> (FETCH -> ISSUE)* -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= 4'd0;
            r_count      <= 4'd0;
            r_first      <= 1'b0;
            r_model_sel  <= 2'd0;
            r_tri_valid  <= 1'b0;
            r_tri_v0     <= 30'd0;
            r_tri_v1     <= 30'd0;
            r_tri_v2     <= 30'd0;
            r_tri_color  <= 12'd0;
            r_tri_index  <= 4'd0;
            r_tri_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            // A request outside IDLE is dropped but remembered.
            if (frame_start && (r_state != c_ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (frame_start) begin
                        r_model_sel <= model_select_in;
                        r_count     <= w_num_clamped;
                        r_first     <= 1'b1;
                        r_idx       <= 4'd0;
                        r_overrun   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= c_ST_FETCH;
                    end
                end

                c_ST_FETCH: begin
                    r_count <= w_count;
                    r_first <= 1'b0;
                    if (w_count == 4'd0) begin
                        r_frame_done <= 1'b1;
                        r_state      <= c_ST_DONE;
                    end else begin
                        r_tri_v0    <= scene_vertices[w_tri[20:18]];
                        r_tri_v1    <= scene_vertices[w_tri[17:15]];
                        r_tri_v2    <= scene_vertices[w_tri[14:12]];
                        r_tri_color <= w_tri[11:0];
                        r_tri_index <= r_idx;
                        r_tri_last  <= (r_idx == (w_count - 4'd1));
                        r_tri_valid <= 1'b1;
                        r_state     <= c_ST_ISSUE;
                    end
                end

                c_ST_ISSUE: begin
                    // Outputs are frozen here until the consumer accepts.
                    if (tri_ready) begin
                        r_tri_valid <= 1'b0;
                        if (r_tri_last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= c_ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= c_ST_FETCH;
                        end
                    end
                end

                c_ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign model_sel  = r_model_sel;
    assign tri_valid  = r_tri_valid;
    assign tri_v0     = r_tri_v0;
    assign tri_v1     = r_tri_v1;
    assign tri_v2     = r_tri_v2;
    assign tri_color  = r_tri_color;
    assign tri_index  = r_tri_index;
    assign tri_last   = r_tri_last;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_triangle_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_triangle_scheduler
// Brief    : Self-checking bench for triangle_scheduler. A behavioural scene
//            source supplies cube/pyramid/octahedron geometry; each frame's
//            expected triangle stream and timing are derived from the tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_triangle_scheduler;

    localparam int c_MAX_TRIS = 12;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         frame_start;
    logic [1:0]                   model_select_in;
    logic [1:0]                   model_sel;
    logic [7:0][29:0]             scene_vertices;
    logic [c_MAX_TRIS-1:0][20:0]  scene_triangles;
    logic [3:0]                   num_triangles;
    logic                         tri_valid;
    logic                         tri_ready;
    logic [29:0]                  tri_v0;
    logic [29:0]                  tri_v1;
    logic [29:0]                  tri_v2;
    logic [11:0]                  tri_color;
    logic [3:0]                   tri_index;
    logic                         tri_last;
    logic                         frame_done;
    logic                         busy;
    logic                         overrun;

    bit                           force_en;
    logic [3:0]                   force_num;

    int n_checks = 0;
    int n_pass   = 0;

    triangle_scheduler #(.MAX_TRIS(c_MAX_TRIS)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .model_select_in (model_select_in),
        .model_sel       (model_sel),
        .scene_vertices  (scene_vertices),
        .scene_triangles (scene_triangles),
        .num_triangles   (num_triangles),
        .tri_valid       (tri_valid),
        .tri_ready       (tri_ready),
        .tri_v0          (tri_v0),
        .tri_v1          (tri_v1),
        .tri_v2          (tri_v2),
        .tri_color       (tri_color),
        .tri_index       (tri_index),
        .tri_last        (tri_last),
        .frame_done      (frame_done),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Scene geometry (behavioural stand-in for scene_objects)
    // ------------------------------------------------------------------------
    function automatic int model_tris(input int m);
        case (m)
            0:       return 12;
            1:       return 6;
            2:       return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [29:0] vert(input int m, input int i);
        int x, y, z;
        x = 0; y = 0; z = 0;
        case (m)
            0: begin
                x = ((i % 4 == 1) || (i % 4 == 2)) ? -80 : 80;
                y = (i % 4 >= 2) ? -80 : 80;
                z = (i < 4) ? 80 : -80;
            end
            1: begin
                case (i)
                    0: y = 100;
                    1: begin x = -80; y = -60; z =  80; end
                    2: begin x =  80; y = -60; z =  80; end
                    3: begin x =  80; y = -60; z = -80; end
                    4: begin x = -80; y = -60; z = -80; end
                    default: ;
                endcase
            end
            2: begin
                case (i)
                    0: x =  100;
                    1: x = -100;
                    2: y =  100;
                    3: y = -100;
                    4: z =  100;
                    5: z = -100;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return {10'(x), 10'(y), 10'(z)};
    endfunction

    function automatic logic [20:0] tri_of(input int m, input int k);
        int          t [36];
        logic [11:0] col [12];
        for (int j = 0; j < 36; j++) t[j] = 0;
        for (int j = 0; j < 12; j++) col[j] = 12'h000;
        case (m)
            0: begin
                t   = '{0,1,2, 0,2,3, 4,6,5, 4,7,6, 0,4,5, 0,5,1,
                        1,5,6, 1,6,2, 2,6,7, 2,7,3, 3,7,4, 3,4,0};
                col = '{12'hF00, 12'hF00, 12'h0F0, 12'h0F0, 12'h00F, 12'h00F,
                        12'hFF0, 12'hFF0, 12'h0FF, 12'h0FF, 12'hF0F, 12'hF0F};
            end
            1: begin
                t   = '{0,1,2, 0,2,3, 0,3,4, 0,4,1, 1,3,2, 1,4,3,
                        0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0};
                col = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'hF0F,
                        12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
            end
            2: begin
                t   = '{4,0,2, 4,2,1, 4,1,3, 4,3,0, 5,2,0, 5,1,2,
                        5,3,1, 5,0,3, 0,0,0, 0,0,0, 0,0,0, 0,0,0};
                for (int j = 0; j < 8; j++) col[j] = {3{4'(j + 1)}};
            end
            default: ;
        endcase
        if (k >= model_tris(m)) return 21'd0;
        return {3'(t[3*k]), 3'(t[3*k+1]), 3'(t[3*k+2]), col[k]};
    endfunction

    // Geometry follows the scheduler's registered model selection.
    always_comb begin
        for (int i = 0; i < 8; i++) scene_vertices[i] = vert(int'(model_sel), i);
        for (int k = 0; k < c_MAX_TRIS; k++) scene_triangles[k] = tri_of(int'(model_sel), k);
        num_triangles = force_en ? force_num : 4'(model_tris(int'(model_sel)));
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One frame: start pulse, consumer behaviour per ready_mode
    // (0 always ready, 1 three stall cycles per triangle, 2 random),
    // optional stray frame_start pulses, optional reset at a given index.
    task automatic run_frame(input int m, input int ready_mode, input bit fs_mid,
                             input int rst_idx, input bit sw_model);
        int          cnt, cyc, issued, first_valid, last_hs, done_cyc, stall;
        bit          prev_stall;
        logic        rdy;
        logic [20:0] t;
        logic [29:0] h0, h1, h2;
        logic [11:0] hc;
        logic [3:0]  hi;
        logic        hl;

        cnt = force_en ? ((int'(force_num) > c_MAX_TRIS) ? c_MAX_TRIS : int'(force_num))
                       : model_tris(m);
        h0 = '0; h1 = '0; h2 = '0; hc = '0; hi = '0; hl = 1'b0;

        @(negedge clk);
        model_select_in = 2'(m);
        frame_start     = 1'b1;
        tri_ready       = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        cyc = 1;
        if (sw_model) model_select_in = 2'd0;
        check("busy_cycle1", 32'(busy), 32'd1);
        check("model_sel_latched", 32'(model_sel), 32'(m));
        check("overrun_cleared", 32'(overrun), 32'd0);

        issued = 0; first_valid = -1; last_hs = -1; done_cyc = -1;
        stall = 0; prev_stall = 1'b0;

        while ((done_cyc < 0) && (cyc < 200)) begin
            rdy = 1'b0;
            if (prev_stall) begin
                check("hold_valid", 32'(tri_valid), 32'd1);
                check("hold_v0",    32'(tri_v0),    32'(h0));
                check("hold_v1",    32'(tri_v1),    32'(h1));
                check("hold_v2",    32'(tri_v2),    32'(h2));
                check("hold_color", 32'(tri_color), 32'(hc));
                check("hold_index", 32'(tri_index), 32'(hi));
                check("hold_last",  32'(tri_last),  32'(hl));
            end
            prev_stall = 1'b0;
            if (tri_valid) begin
                if (first_valid < 0) first_valid = cyc;
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (stall >= 3);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                if ((rst_idx >= 0) && (int'(tri_index) == rst_idx)) begin
                    rst       = 1'b1;
                    tri_ready = 1'b0;
                    @(negedge clk);
                    check("rst_valid", 32'(tri_valid),  32'd0);
                    check("rst_index", 32'(tri_index),  32'd0);
                    check("rst_last",  32'(tri_last),   32'd0);
                    check("rst_v0",    32'(tri_v0),     32'd0);
                    check("rst_color", 32'(tri_color),  32'd0);
                    check("rst_model", 32'(model_sel),  32'd0);
                    check("rst_busy",  32'(busy),       32'd0);
                    check("rst_done",  32'(frame_done), 32'd0);
                    rst = 1'b0;
                    @(negedge clk);
                    check("rst_no_done", 32'(frame_done), 32'd0);
                    check("rst_idle",    32'(busy),       32'd0);
                    return;
                end
                if (fs_mid && (tri_index == 4'd3) && (stall == 0)) frame_start = 1'b1;
                if (rdy) begin
                    if (issued < cnt) begin
                        t = tri_of(m, issued);
                        check("tri_v0",    32'(tri_v0),    32'(vert(m, int'(t[20:18]))));
                        check("tri_v1",    32'(tri_v1),    32'(vert(m, int'(t[17:15]))));
                        check("tri_v2",    32'(tri_v2),    32'(vert(m, int'(t[14:12]))));
                        check("tri_color", 32'(tri_color), 32'(t[11:0]));
                        check("tri_index", 32'(tri_index), 32'(issued));
                        check("tri_last",  32'(tri_last),  32'(issued == cnt - 1));
                    end else begin
                        check("extra_triangle", 32'(issued), 32'(cnt));
                    end
                    if (ready_mode == 0) check("valid_cycle", 32'(cyc), 32'(2 + 2 * issued));
                    issued++;
                    last_hs = cyc;
                    stall   = 0;
                end else begin
                    stall++;
                    prev_stall = 1'b1;
                    h0 = tri_v0; h1 = tri_v1; h2 = tri_v2;
                    hc = tri_color; hi = tri_index; hl = tri_last;
                end
            end
            if (frame_done) begin
                done_cyc = cyc;
                check("busy_at_done", 32'(busy), 32'd1);
                if (fs_mid) frame_start = 1'b1;
            end
            tri_ready = rdy;
            @(negedge clk);
            frame_start = 1'b0;
            tri_ready   = 1'b0;
            cyc++;
        end

        if (done_cyc < 0) check("frame_timeout", 32'd0, 32'd1);
        check("issued_count", 32'(issued), 32'(cnt));
        check("first_valid",  32'(first_valid), (cnt > 0) ? 32'd2 : 32'hFFFF_FFFF);
        check("done_cycle",   32'(done_cyc), (cnt > 0) ? 32'(last_hs + 1) : 32'd2);
        check("done_single",  32'(frame_done), 32'd0);
        check("busy_after",   32'(busy), 32'd0);
        check("model_held",   32'(model_sel), 32'(m));
        check("overrun_end",  32'(overrun), 32'(fs_mid));
        @(negedge clk);
        check("no_restart",   32'(busy), 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1; frame_start = 1'b0; tri_ready = 1'b0;
        model_select_in = 2'd0; force_en = 1'b0; force_num = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_valid",   32'(tri_valid),  32'd0);
        check("reset_model",   32'(model_sel),  32'd0);
        check("reset_busy",    32'(busy),       32'd0);
        check("reset_overrun", 32'(overrun),    32'd0);
        check("reset_done",    32'(frame_done), 32'd0);
        check("reset_index",   32'(tri_index),  32'd0);
        check("reset_last",    32'(tri_last),   32'd0);
        check("reset_v0",      32'(tri_v0),     32'd0);
        check("reset_color",   32'(tri_color),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(0, 0, 1'b0, -1, 1'b0);      // cube, always ready
        run_frame(1, 1, 1'b0, -1, 1'b0);      // pyramid, stalled consumer
        run_frame(2, 2, 1'b0, -1, 1'b1);      // octahedron, selection changed mid-frame
        run_frame(0, 2, 1'b1, -1, 1'b0);      // stray frame_start mid-frame and in DONE
        check("overrun_sticky", 32'(overrun), 32'd1);
        run_frame(1, 0, 1'b0, -1, 1'b0);      // accepted start clears overrun
        run_frame(0, 2, 1'b0,  5, 1'b0);      // reset on triangle 5
        run_frame(0, 0, 1'b0, -1, 1'b0);      // fresh frame from index 0

        force_en = 1'b1; force_num = 4'd0;
        run_frame(0, 0, 1'b0, -1, 1'b0);      // empty frame
        force_num = 4'd15;
        run_frame(2, 2, 1'b0, -1, 1'b0);      // clamped to MAX_TRIS
        force_en = 1'b0;

        for (int r = 0; r < 6; r++) begin
            force_en  = ($urandom_range(0, 3) == 0);
            force_num = 4'($urandom_range(0, 15));
            run_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), -1, 1'b0);
        end
        force_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound in case a frame never terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time bound, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
